// File: rtl/poly_mult_seq.sv
// Sequential polynomial multiplier over Z_(2^W)[x]/(x^N -/+ 1): loads N operand
// beats, runs N*N single-MAC cycles, then streams the N result coefficients.
module poly_mult_seq #(
   parameter int N = 4,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a_in,
   input  logic [W-1:0] b_in,
   input  logic         mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy
);

   localparam int LOG = $clog2(N);
   localparam logic [LOG-1:0] LAST   = LOG'(N - 1);
   localparam logic [LOG-1:0] PENULT = LOG'(N - 2);

   typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

   state_t         state_q;
   logic [W-1:0]   a_q   [N];
   logic [W-1:0]   b_q   [N];
   logic [W-1:0]   acc_q [N];
   logic [LOG-1:0] beat_q, i_q, j_q, idx_q;
   logic           mode_q;
   logic           in_ready_q, out_valid_q, out_last_q, busy_q;

   // Carry out of i+j flags a wrap past x^N; the low bits are (i+j) mod N.
   logic [LOG:0]   ij_sum;
   logic [LOG-1:0] k;
   logic           wrap;
   logic [W-1:0]   prod, acc_d;

   assign ij_sum = {1'b0, i_q} + {1'b0, j_q};
   assign k      = ij_sum[LOG-1:0];
   assign wrap   = ij_sum[LOG];
   assign prod   = a_q[i_q] * b_q[j_q];
   assign acc_d  = (wrap && mode_q) ? acc_q[k] - prod : acc_q[k] + prod;

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign out_data  = out_valid_q ? acc_q[idx_q] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= LOAD;
         beat_q      <= '0;
         i_q         <= '0;
         j_q         <= '0;
         idx_q       <= '0;
         mode_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         for (int n = 0; n < N; n++) begin
            a_q[n]   <= '0;
            b_q[n]   <= '0;
            acc_q[n] <= '0;
         end
      end else begin
         case (state_q)
            LOAD: begin
               if (in_valid) begin
                  a_q[beat_q] <= a_in;
                  b_q[beat_q] <= b_in;
                  if (beat_q == '0) mode_q <= mode;
                  if (beat_q == LAST) begin
                     beat_q     <= '0;
                     i_q        <= '0;
                     j_q        <= '0;
                     state_q    <= COMPUTE;
                     in_ready_q <= 1'b0;
                     busy_q     <= 1'b1;
                     for (int n = 0; n < N; n++) acc_q[n] <= '0;
                  end else begin
                     beat_q <= beat_q + 1'b1;
                  end
               end
            end
            COMPUTE: begin
               acc_q[k] <= acc_d;
               if (j_q == LAST) begin
                  j_q <= '0;
                  if (i_q == LAST) begin
                     i_q         <= '0;
                     idx_q       <= '0;
                     state_q     <= OUTPUT;
                     out_valid_q <= 1'b1;
                     out_last_q  <= 1'b0;
                  end else begin
                     i_q <= i_q + 1'b1;
                  end
               end else begin
                  j_q <= j_q + 1'b1;
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  if (idx_q == LAST) begin
                     idx_q       <= '0;
                     state_q     <= LOAD;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     busy_q      <= 1'b0;
                     in_ready_q  <= 1'b1;
                  end else begin
                     idx_q      <= idx_q + 1'b1;
                     out_last_q <= (idx_q == PENULT);
                  end
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_poly_mult_seq.sv
// Randomized bench for poly_mult_seq (N=4, W=4) against a plain convolution model.
module tb_poly_mult_seq;

   localparam int N = 4;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         mode = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         out_last;
   logic         busy;

   poly_mult_seq #(.N(N), .W(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .mode(mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         l;
   } exp_t;

   exp_t expq[$];
   int   nchk = 0;
   int   nerr = 0;

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Schoolbook product folded back by x^N = 1 (cyclic) or x^N = -1 (negacyclic).
   function automatic void model(input logic [W-1:0] a[N], input logic [W-1:0] b[N],
                                 input logic m, output logic [W-1:0] r[N]);
      int acc[N];
      for (int k = 0; k < N; k++) acc[k] = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            if (i + j < N || !m) acc[(i + j) % N] += int'(a[i]) * int'(b[j]);
            else                 acc[(i + j) % N] -= int'(a[i]) * int'(b[j]);
         end
      for (int k = 0; k < N; k++) r[k] = W'(acc[k]);
   endfunction

   // Compare process: every cycle the result is presented it must match the head.
   always @(negedge clk) begin
      if (!reset) begin
         chk("in_ready_vs_busy", int'(in_ready), int'(!busy));
         if (out_valid) begin
            chk("in_ready_in_output", int'(in_ready), 0);
            if (expq.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               chk("out_data", int'(out_data), int'(expq[0].d));
               chk("out_last", int'(out_last), int'(expq[0].l));
               if (out_ready) void'(expq.pop_front());
            end
         end else begin
            chk("out_last_idle", int'(out_last), 0);
         end
      end
   end

   task automatic load_txn(input logic [W-1:0] a[N], input logic [W-1:0] b[N],
                           input logic m, input bit gaps);
      logic [W-1:0] r[N];
      exp_t e;
      for (int k = 0; k < N; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               a_in = W'($urandom); b_in = W'($urandom); mode = 1'($urandom);
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1;
         a_in = a[k];
         b_in = b[k];
         mode = (k == 0) ? m : 1'($urandom);
         chk("in_ready_load", int'(in_ready), 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      model(a, b, m, r);
      for (int k = 0; k < N; k++) begin
         e.d = r[k];
         e.l = (k == N - 1);
         expq.push_back(e);
      end
   endtask

   // Counts edges from the last load edge to out_valid, throwing noise at the inputs.
   task automatic wait_result(input bit noise);
      int cnt = 0;
      while (!out_valid && cnt < 40) begin
         if (noise) begin
            in_valid = 1'($urandom); a_in = W'($urandom); b_in = W'($urandom);
            mode = 1'($urandom);
         end
         @(posedge clk); #1;
         cnt++;
         if (!out_valid) chk("in_ready_compute", int'(in_ready), 0);
      end
      chk("latency", cnt, N * N);
   endtask

   // pat: 0 = always ready, 1 = random backpressure, 2 = stall 5 cycles at idx 1.
   task automatic drain(input int pat, input bit noise);
      int acc = 0;
      int hold = 0;
      int cyc = 0;
      while (acc < N && cyc < 200) begin
         case (pat)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom);
            default: begin
               if (acc == 1 && hold < 5) begin out_ready = 1'b0; hold++; end
               else out_ready = 1'b1;
            end
         endcase
         if (noise) begin
            in_valid = 1'($urandom); a_in = W'($urandom); b_in = W'($urandom);
         end
         if (out_valid && out_ready) acc++;
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= 200) chk("drain_timeout", 0, 1);
      out_ready = 1'b0;
      in_valid = 1'b0;
      chk("back_to_load", int'(in_ready), 1);
      chk("queue_empty", expq.size(), 0);
   endtask

   task automatic run(input logic [W-1:0] a[N], input logic [W-1:0] b[N],
                      input logic m, input int pat, input bit noise);
      load_txn(a, b, m, noise);
      wait_result(noise);
      drain(pat, noise);
   endtask

   initial begin
      logic [W-1:0] ta[N], tb[N], r[N];

      // Hand-computed values that pin the model itself.
      ta = '{4'd1, 4'd2, 4'd0, 4'd0}; tb = '{4'd3, 4'd1, 4'd0, 4'd0};
      model(ta, tb, 1'b0, r);
      chk("model_030_0", int'(r[0]), 3); chk("model_030_1", int'(r[1]), 7);
      chk("model_030_2", int'(r[2]), 2); chk("model_030_3", int'(r[3]), 0);
      ta = '{4'd0, 4'd0, 4'd0, 4'd1}; tb = '{4'd0, 4'd1, 4'd0, 4'd0};
      model(ta, tb, 1'b1, r);
      chk("model_031_neg", int'(r[0]), 15);
      model(ta, tb, 1'b0, r);
      chk("model_031_cyc", int'(r[0]), 1);
      ta = '{4'd15, 4'd0, 4'd0, 4'd0}; tb = '{4'd15, 4'd0, 4'd0, 4'd0};
      model(ta, tb, 1'b0, r);
      chk("model_032", int'(r[0]), 1);

      // Asynchronous reset: outputs settle before any clock edge.
      #2 reset = 1'b1;
      #2;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_out_data", int'(out_data), 0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      ta = '{4'd1, 4'd2, 4'd0, 4'd0}; tb = '{4'd3, 4'd1, 4'd0, 4'd0};
      run(ta, tb, 1'b0, 0, 1'b0);
      ta = '{4'd0, 4'd0, 4'd0, 4'd1}; tb = '{4'd0, 4'd1, 4'd0, 4'd0};
      run(ta, tb, 1'b1, 0, 1'b0);
      run(ta, tb, 1'b0, 0, 1'b0);
      ta = '{4'd15, 4'd0, 4'd0, 4'd0}; tb = '{4'd15, 4'd0, 4'd0, 4'd0};
      run(ta, tb, 1'b0, 0, 1'b0);
      ta = '{4'd1, 4'd2, 4'd0, 4'd0}; tb = '{4'd3, 4'd1, 4'd0, 4'd0};
      run(ta, tb, 1'b0, 2, 1'b0);

      // Reset in the middle of COMPUTE, then reload the same operands.
      load_txn(ta, tb, 1'b0, 1'b0);
      repeat (7) @(posedge clk);
      #1 reset = 1'b1;
      expq.delete();
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      chk("midrst_busy", int'(busy), 0);
      @(posedge clk); #1;
      chk("midrst_hold_ready", int'(in_ready), 1);
      reset = 1'b0;
      run(ta, tb, 1'b0, 0, 1'b0);

      // Reset in the middle of LOAD: next beat must be beat 0 again.
      in_valid = 1'b1; a_in = 4'd9; b_in = 4'd9; mode = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      run(ta, tb, 1'b0, 1, 1'b0);

      // Randomized operands, mode, gaps, backpressure and input noise.
      for (int t = 0; t < 24; t++) begin
         for (int k = 0; k < N; k++) begin
            ta[k] = W'($urandom);
            tb[k] = W'($urandom);
         end
         run(ta, tb, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/poly_mult_seq.md
POLY_MULT_SEQ -- requirements
Module: poly_mult_seq

Interface
REQ-001 SHALL have parameter N, default 4: number of coefficients per operand polynomial; N is a power of two, 2..16.
REQ-002 SHALL have parameter W, default 4: coefficient width in bits; all arithmetic is mod 2^W.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat valid.
REQ-006 SHALL have port in_ready  output  1  block accepts an operand beat.
REQ-007 SHALL have port a_in  input  W  coefficient of operand A for the current beat.
REQ-008 SHALL have port b_in  input  W  coefficient of operand B for the current beat.
REQ-009 SHALL have port mode  input  1  reduction mode: 0 = cyclic (x^N-1), 1 = negacyclic (x^N+1).
REQ-010 SHALL have port out_valid  output  1  result coefficient valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result coefficient.
REQ-012 SHALL have port out_data  output  W  result coefficient.
REQ-013 SHALL have port out_last  output  1  marks coefficient N-1 of the result.
REQ-014 SHALL have port busy  output  1  high in COMPUTE and OUTPUT.

Function
REQ-015 SHALL implement FSM states LOAD, COMPUTE, OUTPUT; LOAD is the reset state.
REQ-016 LOAD: in_ready=1; a beat is accepted on an edge with in_valid&&in_ready; beats arrive index 0 first, pair (a_in,b_in) stored at index k.
REQ-017 mode SHALL be latched on the edge accepting beat 0; mode changes during later beats are ignored.
REQ-018 The edge accepting beat N-1 SHALL clear all N accumulators and move to COMPUTE.
REQ-019 COMPUTE: one MAC per edge over i (outer) and j (inner), 0..N-1, exactly N*N edges.
REQ-020 MAC target index k=(i+j) mod N; if i+j<N, or mode=0, acc[k] += a[i]*b[j]; else acc[k] -= a[i]*b[j]; all results truncated to W bits.
REQ-021 The edge performing MAC (N-1,N-1) SHALL move to OUTPUT; out_valid therefore rises exactly N*N edges after the edge accepting beat N-1.
REQ-022 COMPUTE: in_ready=0, out_valid=0; in_valid and operand inputs ignored.
REQ-023 OUTPUT: out_valid=1, out_data=acc[idx], idx starts at 0; idx advances on out_valid&&out_ready.
REQ-024 out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 out_last=1 only when idx=N-1; the edge accepting idx N-1 SHALL return to LOAD with in_ready=1 on the following cycle.
REQ-026 OUTPUT: in_ready=0; no new operand accepted until return to LOAD.
REQ-027 Throughput: one full product every N + N*N + N cycles with in_valid and out_ready held high.

Reset
REQ-028 reset=1 SHALL immediately (without clock) force state LOAD, beat/idx/i/j counters to 0, out_valid=0, out_last=0, out_data=0, busy=0, in_ready=1, latched mode=0.
REQ-029 Reset in any state (mid-load, mid-compute, mid-output) SHALL abandon the operation; partial beats and accumulators are discarded, and the next accepted beat is treated as beat 0.

Verification (N=4, W=4)
REQ-030 A=[1,2,0,0], B=[3,1,0,0], mode=0 -> out_data sequence 3,7,2,0, out_last on 4th, first out_valid 16 edges after last load.
REQ-031 A=[0,0,0,1], B=[0,1,0,0]: mode=1 -> 15,0,0,0; mode=0 -> 1,0,0,0.
REQ-032 A=[15,0,0,0], B=[15,0,0,0] -> 1,0,0,0 (225 mod 16 wrap).
REQ-033 out_ready low 5 cycles at idx 1 of REQ-030 -> out_data holds 7, out_last=0, no skipped or repeated coefficient.
REQ-034 reset pulse at 8th COMPUTE cycle, then REQ-030 operands reloaded -> out_valid=0 and in_ready=1 during reset; correct result 3,7,2,0 afterwards.
REQ-035 in_valid toggling during COMPUTE/OUTPUT with random data -> ignored; result unchanged, in_ready=0 throughout.
